// File: rtl/char_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : char_renderer
//  Description : Text-mode pixel front end. Maps VGA pixel coordinates to
//                text-buffer addresses and glyph LUT lookups, returns a
//                per-pixel lit/unlit decision with a blinking block cursor.
//                Two-cycle pipeline, one pixel per clock, no backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module char_renderer #(
    parameter int COLS         = 80,
    parameter int ROWS         = 60,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    input  logic        in_valid,
    input  logic [9:0]  in_x,
    input  logic [9:0]  in_y,
    input  logic        in_frame_start,
    output logic [12:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic [7:0]  lut_char,
    output logic [2:0]  lut_vidx,
    output logic [2:0]  lut_hidx,
    input  logic        lut_lit,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [5:0]  cursor_row,
    output logic        out_valid,
    output logic        out_lit
);

    // Visible text area limits in pixels (11 bits so 1024 is representable)
    localparam logic [10:0] c_x_lim = 11'(COLS * 8);
    localparam logic [10:0] c_y_lim = 11'(ROWS * 8);
    localparam logic [12:0] c_cols  = 13'(COLS);

    // Blink counter only needs to reach BLINK_FRAMES-1
    localparam int                 c_cnt_w    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BLINK_FRAMES - 1);

    // ------------------------------------------------------------------
    // Stage 0: cell decode
    // ------------------------------------------------------------------
    logic [6:0]  w_col;
    logic [6:0]  w_row;
    logic [2:0]  w_vidx;
    logic [2:0]  w_hidx;
    logic        w_in_range;
    logic        w_cur_hit;
    logic [12:0] w_addr;

    assign w_col      = in_x[9:3];
    assign w_row      = in_y[9:3];
    assign w_vidx     = in_y[2:0];
    assign w_hidx     = in_x[2:0];
    assign w_in_range = ({1'b0, in_x} < c_x_lim) && ({1'b0, in_y} < c_y_lim);
    assign w_addr     = ({6'd0, w_row} * c_cols) + {6'd0, w_col};

    // Blink state registers
    logic [c_cnt_w-1:0] r_blink_cnt;
    logic               r_blink_on;

    // Cursor match uses the blink phase before any same-cycle frame update
    assign w_cur_hit = cursor_en && (w_col == cursor_col) &&
                       (w_row == {1'b0, cursor_row}) && r_blink_on;

    // Address only presented for visible, valid pixels; otherwise park at 0
    assign mem_addr = (in_valid && w_in_range) ? w_addr : 13'd0;

    // Blink counter: advance per frame, wrap and toggle the cursor phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (in_frame_start) begin
            if (r_blink_cnt == c_cnt_last) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: aligned with the buffer read data
    // ------------------------------------------------------------------
    logic       r_s1_valid;
    logic       r_s1_blank;
    logic [2:0] r_s1_vidx;
    logic [2:0] r_s1_hidx;
    logic       r_s1_cur_hit;

    // Carry per-pixel context alongside the one-cycle buffer read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_blank   <= 1'b0;
            r_s1_vidx    <= 3'd0;
            r_s1_hidx    <= 3'd0;
            r_s1_cur_hit <= 1'b0;
        end else begin
            r_s1_valid   <= in_valid;
            r_s1_blank   <= ~w_in_range;
            r_s1_vidx    <= w_vidx;
            r_s1_hidx    <= w_hidx;
            r_s1_cur_hit <= w_cur_hit;
        end
    end

    // Glyph LUT request; quiet when no visible pixel is in stage 1
    assign lut_char = (r_s1_valid && !r_s1_blank) ? mem_data : 8'd0;
    assign lut_vidx = r_s1_valid ? r_s1_vidx : 3'd0;
    assign lut_hidx = r_s1_valid ? r_s1_hidx : 3'd0;

    logic w_pix_lit;
    assign w_pix_lit = r_s1_valid && !r_s1_blank && (lut_lit ^ r_s1_cur_hit);

    // ------------------------------------------------------------------
    // Stage 2: output register
    // ------------------------------------------------------------------
    logic r_out_valid;
    logic r_out_lit;

    // Register the final pixel decision
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_lit   <= 1'b0;
        end else begin
            r_out_valid <= r_s1_valid;
            r_out_lit   <= w_pix_lit;
        end
    end

    assign out_valid = r_out_valid;
    assign out_lit   = r_out_lit;

endmodule
`default_nettype wire

// File: tb/tb_char_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_char_renderer
//  Description : Directed self-checking bench for char_renderer with a
//                behavioural text buffer and a small glyph LUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_char_renderer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [9:0]  in_x = '0;
    logic [9:0]  in_y = '0;
    logic        in_frame_start = 1'b0;
    logic [12:0] mem_addr;
    logic [7:0]  mem_data = 8'd0;
    logic [7:0]  lut_char;
    logic [2:0]  lut_vidx;
    logic [2:0]  lut_hidx;
    logic        lut_lit;
    logic        cursor_en = 1'b0;
    logic [6:0]  cursor_col = '0;
    logic [5:0]  cursor_row = '0;
    logic        out_valid;
    logic        out_lit;

    int checks = 0;
    int errors = 0;

    logic [7:0] tmem [0:8191];

    char_renderer #(.COLS(80), .ROWS(60), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
        .in_frame_start(in_frame_start), .mem_addr(mem_addr), .mem_data(mem_data),
        .lut_char(lut_char), .lut_vidx(lut_vidx), .lut_hidx(lut_hidx),
        .lut_lit(lut_lit), .cursor_en(cursor_en), .cursor_col(cursor_col),
        .cursor_row(cursor_row), .out_valid(out_valid), .out_lit(out_lit)
    );

    always #5 clk = ~clk;

    // Text buffer: synchronous read, one-cycle latency
    always @(posedge clk) mem_data <= tmem[mem_addr];

    // Glyph rows, MSB is the leftmost pixel
    function automatic logic [7:0] glyph_row(input logic [7:0] ch, input logic [2:0] v);
        logic [7:0] r;
        r = 8'h00;
        if (ch == 8'h41) begin
            case (v)
                3'd0: r = 8'h30; 3'd1: r = 8'h78; 3'd2: r = 8'hCC; 3'd3: r = 8'hCC;
                3'd4: r = 8'hFC; 3'd5: r = 8'hCC; 3'd6: r = 8'hCC; default: r = 8'h00;
            endcase
        end else if (ch == 8'h71) begin
            case (v)
                3'd2: r = 8'h76; 3'd3: r = 8'hCC; 3'd4: r = 8'hCC;
                3'd5: r = 8'h7C; 3'd6: r = 8'h0C; 3'd7: r = 8'h1E; default: r = 8'h00;
            endcase
        end
        return r;
    endfunction

    logic [7:0] lut_row;
    always_comb begin
        lut_row = glyph_row(lut_char, lut_vidx);
        lut_lit = lut_row[3'd7 - lut_hidx];
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        in_frame_start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        in_frame_start = 1'b1;
        @(negedge clk);
        in_frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_lit !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: out_valid=%b out_lit=%b expected 0 0", out_valid, out_lit);
        end
        checks++;
        if (mem_addr !== 13'd0 || lut_char !== 8'd0 || lut_vidx !== 3'd0 || lut_hidx !== 3'd0) begin
            errors++;
            $display("FAIL reset_lut: addr=%0d char=%h v=%0d h=%0d expected all 0",
                     mem_addr, lut_char, lut_vidx, lut_hidx);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_glyph_row0();
        logic [7:0] exp_row;
        exp_row = 8'b0011_0000;
        cursor_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 8) begin
                in_valid = 1'b1; in_x = 10'(i); in_y = 10'd0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checks++;
            if (i < 2) begin
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL glyph_latency cyc%0d: out_valid=%b expected 0", i, out_valid);
                end
            end else if (out_valid !== 1'b1 || out_lit !== exp_row[9 - i]) begin
                errors++;
                $display("FAIL glyph_row0 px%0d: valid=%b lit=%b expected valid=1 lit=%b",
                         i - 2, out_valid, out_lit, exp_row[9 - i]);
            end
        end
    endtask

    task automatic test_addressing();
        @(negedge clk);
        in_valid = 1'b1; in_x = 10'd17; in_y = 10'd10;
        #1;
        checks++;
        if (mem_addr !== 13'd82) begin
            errors++;
            $display("FAIL addr: mem_addr=%0d expected 82", mem_addr);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (lut_vidx !== 3'd2 || lut_hidx !== 3'd1 || lut_char !== 8'h71) begin
            errors++;
            $display("FAIL lut_req: v=%0d h=%0d char=%h expected v=2 h=1 char=71",
                     lut_vidx, lut_hidx, lut_char);
        end
        repeat (2) @(negedge clk);
    endtask

    // Stream cell (2,1) glyph row 2 and compare against the expected row bits
    task automatic test_cell_row(input logic [7:0] exp_row, input string tag);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 8) begin
                in_valid = 1'b1; in_x = 10'(16 + i); in_y = 10'd10;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_lit !== exp_row[9 - i]) begin
                    errors++;
                    $display("FAIL %s px%0d: valid=%b lit=%b expected valid=1 lit=%b",
                             tag, i - 2, out_valid, out_lit, exp_row[9 - i]);
                end
            end
        end
    endtask

    task automatic test_cursor();
        do_reset();
        cursor_en = 1'b1; cursor_col = 7'd2; cursor_row = 6'd1;
        test_cell_row(8'b1000_1001, "cursor_inv");
    endtask

    task automatic test_blink();
        pulse_frame();
        pulse_frame();
        test_cell_row(8'b0111_0110, "blink_off");
        pulse_frame();
        pulse_frame();
        test_cell_row(8'b1000_1001, "blink_on");
    endtask

    // Frame pulse coinciding with a pixel: that pixel sees the old phase
    task automatic test_simultaneous();
        pulse_frame();
        @(negedge clk);
        in_frame_start = 1'b1; in_valid = 1'b1; in_x = 10'd16; in_y = 10'd10;
        @(negedge clk);
        in_frame_start = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_lit !== 1'b1) begin
            errors++;
            $display("FAIL simul_pre: valid=%b lit=%b expected 1 1", out_valid, out_lit);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_lit !== 1'b0) begin
            errors++;
            $display("FAIL simul_post: valid=%b lit=%b expected 1 0", out_valid, out_lit);
        end
        @(negedge clk);
    endtask

    task automatic test_blank_gaps();
        logic [4:0] exp_v;
        logic [4:0] exp_l;
        do_reset();
        cursor_en = 1'b1; cursor_col = 7'd80; cursor_row = 6'd0;
        // pixels: (640,0) (2,480) (2,0) idle (3,0)
        exp_v = 5'b11101;
        exp_l = 5'b00101;
        @(negedge clk);
        in_valid = 1'b1; in_x = 10'd640; in_y = 10'd0;
        #1;
        checks++;
        if (mem_addr !== 13'd0) begin
            errors++;
            $display("FAIL blank_addr_x: mem_addr=%0d expected 0", mem_addr);
        end
        @(negedge clk);
        in_x = 10'd2; in_y = 10'd480;
        #1;
        checks++;
        if (mem_addr !== 13'd0) begin
            errors++;
            $display("FAIL blank_addr_y: mem_addr=%0d expected 0", mem_addr);
        end
        for (int i = 2; i < 7; i++) begin
            @(negedge clk);
            case (i)
                2: begin in_valid = 1'b1; in_x = 10'd2; in_y = 10'd0; end
                4: begin in_valid = 1'b1; in_x = 10'd3; in_y = 10'd0; end
                default: in_valid = 1'b0;
            endcase
            #1;
            checks++;
            if (out_valid !== exp_v[6 - i] || (exp_v[6 - i] && out_lit !== exp_l[6 - i])) begin
                errors++;
                $display("FAIL blank_gap px%0d: valid=%b lit=%b expected valid=%b lit=%b",
                         i - 2, out_valid, out_lit, exp_v[6 - i], exp_l[6 - i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        cursor_en = 1'b0;
        // leave blink off with the counter mid-count before reset
        pulse_frame();
        pulse_frame();
        pulse_frame();
        @(negedge clk);
        in_valid = 1'b1; in_x = 10'd2; in_y = 10'd0;
        @(negedge clk);
        in_x = 10'd3;
        @(posedge clk);
        #2;
        checks++;
        if (out_valid !== 1'b1 || out_lit !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: valid=%b lit=%b expected 1 1", out_valid, out_lit);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_lit !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: valid=%b lit=%b expected 0 0", out_valid, out_lit);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale cyc%0d: out_valid=%b expected 0", i, out_valid);
            end
        end
        // one pulse must not toggle if the counter restarted at 0
        cursor_en = 1'b1; cursor_col = 7'd2; cursor_row = 6'd1;
        pulse_frame();
        @(negedge clk);
        in_valid = 1'b1; in_x = 10'd16; in_y = 10'd10;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_latency: out_valid=%b expected 0", out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_lit !== 1'b1) begin
            errors++;
            $display("FAIL midrst_blink: valid=%b lit=%b expected 1 1", out_valid, out_lit);
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) tmem[i] = 8'h00;
        tmem[0]  = 8'h41;
        tmem[82] = 8'h71;
        test_reset();
        test_glyph_row0();
        test_addressing();
        test_cursor();
        test_blink();
        test_simultaneous();
        test_blank_gaps();
        test_reset_midstream();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/char_renderer.md
Name: char_renderer

Overview:
- Text-mode pixel front end: turns VGA pixel coordinates into character-cell lookups against the text buffer and the 8x8 glyph LUT, then returns a lit/unlit decision per pixel.
- It is the initiator of the glyph LUT interface (drives char/vidx/hidx, consumes lit).
- Sits between the VGA timing generator and the colour/output stage.
- Adds a blinking block cursor by inverting the lit bit of one cell.

Parameters:
COLS, 80, text columns (cell width 8 px)
ROWS, 60, text rows (cell height 8 px)
BLINK_FRAMES, 30, frames per cursor blink half-period (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  active-video pixel strobe
in_x  in  10  pixel column
in_y  in  10  pixel row
in_frame_start  in  1  one-cycle pulse at start of each frame
mem_addr  out  13  text buffer read address, row*COLS+col
mem_data  in  8  text buffer read data; synchronous read, 1-cycle latency
lut_char  out  8  character code to glyph LUT
lut_vidx  out  3  glyph row to LUT
lut_hidx  out  3  glyph column to LUT
lut_lit  in  1  LUT result, combinational from lut_* outputs
cursor_en  in  1  cursor enable
cursor_col  in  7  cursor cell column
cursor_row  in  6  cursor cell row
out_valid  out  1  pixel result valid
out_lit  out  1  pixel lit (after cursor inversion)

Behaviour:
- Clock and reset: one clock. rst is asynchronous and active-low. While rst=0:
  - all stage registers clear;
  - out_valid=0, out_lit=0;
  - blink counter=0, blink_on=1.
- Cell decode:
  - col=in_x[9:3], row=in_y[9:3], vidx=in_y[2:0], hidx=in_x[2:0].
  - in_range = in_x<COLS*8 and in_y<ROWS*8.
- Stage 0 (cycle t), combinational:
  - mem_addr = row*COLS+col when in_valid and in_range, else 0.
  - Product width: 13 bits, no truncation for defaults.
- Stage 1 register, captured at the end of cycle t:
  - fields: valid=in_valid, blank=!in_range, vidx, hidx, cur_hit.
  - cur_hit = cursor_en and col==cursor_col and row==cursor_row and blink_on.
- Cycle t+1, combinational:
  - lut_char = mem_data when s1.valid and !s1.blank, else 0.
  - lut_vidx = s1.vidx and lut_hidx = s1.hidx, or 0 when s1.valid=0.
- Stage 2 register, captured at the end of cycle t+1:
  - out_valid = s1.valid.
  - out_lit = 0 if s1.blank, else lut_lit XOR s1.cur_hit.
- Latency: exactly 2 cycles from in_valid to out_valid.
  - Throughput: 1 pixel per cycle.
  - Gaps in in_valid appear as out_valid=0 exactly 2 cycles later.
  - No backpressure.
- Out-of-range pixels: out_valid=1, out_lit=0, no cursor inversion.
- Blink state:
  - Counter advances on each in_frame_start.
  - On reaching BLINK_FRAMES-1 it wraps to 0 and toggles blink_on.
  - BLINK_FRAMES=1 toggles on every frame.
- Simultaneous in_frame_start and in_valid: that pixel uses the pre-update blink_on.
- cursor_en=0: no inversion regardless of blink_on. The counter keeps running.
- Cursor inputs are sampled per pixel in stage 0. A mid-frame change takes effect on the next sampled pixel.
- Reset asserted mid-stream:
  - In-flight pixels are dropped; outputs go to 0 immediately.
  - After release, the first out_valid is 2 cycles after the next in_valid.

Test Plan:
- Glyph row 0: buffer addr 0 = "A" (0x41), cursor_en=0; drive y=0, x=0..7 on consecutive cycles -> out_valid high 2 cycles after each input; out_lit sequence 0,0,1,1,0,0,0,0.
- Addressing: in_valid with x=17, y=10 -> same cycle mem_addr=82; next cycle lut_vidx=2, lut_hidx=1, lut_char=mem_data.
- Cursor inversion:
  - Setup: addr 82 = "q", cursor_en=1, cursor_col=2, cursor_row=1, fresh reset (blink_on=1).
  - Stimulus: y=10, x=16..23.
  - Required: out_lit 1,0,0,0,1,0,0,1 (inverse of q row 2: 0,1,1,1,0,1,1,0).
- Blink, BLINK_FRAMES=2:
  - Two in_frame_start pulses -> the same cell renders uninverted (0,1,1,1,0,1,1,0).
  - Two more pulses -> inverted again.
- Blanking and gaps:
  - x=640, y=0 valid -> mem_addr=0; 2 cycles later out_valid=1, out_lit=0.
  - Pattern valid,idle,valid -> out_valid 1,0,1 delayed by 2 cycles.
- Reset mid-stream:
  - Stimulus: drive rst=0 between clock edges with 2 pixels in flight.
  - Required: out_valid=0 and out_lit=0 before the next edge; no stale output after release; blink_on=1 and counter=0.
